// File: rtl/cobs_rx_decoder.sv
// rtl/cobs_rx_decoder.sv - COBS receive decoder with decoded-byte FIFO and throttled strobe output
// Optional statistics counters (o_frames, o_errors) are enabled by defining COBS_DEC_STATS_EN.
module cobs_rx_decoder #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag,
    input  logic [7:0]       data,
    input  logic             busy,
    output logic             o_flag,
    output logic [7:0]       o_data,
    output logic             o_sof,
    output logic             o_err,
    output logic             o_ovf,
    output logic [FIFO_AW:0] fifo_level
`ifdef COBS_DEC_STATS_EN
    ,
    output logic [15:0]      o_frames,
    output logic [15:0]      o_errors
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, CODE, DATA} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pz_q, pz_d;
    logic               push, sof_d, err_d;
    logic [7:0]         push_data;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   level_q;
    logic               o_flag_q, sof_q, err_q, ovf_q;
    logic [7:0]         o_data_q;
    logic               full, pop, push_ok, drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pz_d      = pz_q;
        push      = 1'b0;
        push_data = 8'h00;
        sof_d     = 1'b0;
        err_d     = 1'b0;
        if (flag) begin
            case (state_q)
                IDLE: begin
                    if (data == 8'h00) begin
                        sof_d   = 1'b1;
                        state_d = CODE;
                    end
                end
                CODE: begin
                    if (data == 8'h00) begin
                        sof_d = 1'b1;
                        pz_d  = 1'b0;
                    end else begin
                        // The implicit zero of the previous block lands in the same cycle as this code byte
                        push      = pz_q;
                        push_data = 8'h00;
                        cnt_d     = data - 8'd1;
                        pz_d      = (data != 8'hFF);
                        state_d   = (data == 8'h01) ? CODE : DATA;
                    end
                end
                DATA: begin
                    if (data == 8'h00) begin
                        err_d   = 1'b1;
                        sof_d   = 1'b1;
                        pz_d    = 1'b0;
                        state_d = CODE;
                    end else begin
                        push      = 1'b1;
                        push_data = data;
                        cnt_d     = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = CODE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Level peaks at exactly DEPTH, so its MSB alone marks full
    assign full    = level_q[FIFO_AW];
    assign pop     = (level_q != '0) && !busy && !o_flag_q;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'h00;
            pz_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            o_flag_q <= 1'b0;
            o_data_q <= 8'h00;
            sof_q    <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pz_q     <= pz_d;
            sof_q    <= sof_d;
            err_q    <= err_d;
            o_flag_q <= pop;
            ovf_q    <= ovf_q | drop;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q     <= rd_q + 1'b1;
                o_data_q <= mem_q[rd_q];
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef COBS_DEC_STATS_EN
    logic [15:0] frames_q, errors_q;
    logic        seen_code_q;
    logic        frame_close;

    // A frame counts as non-empty once any code byte has followed its opening delimiter
    assign frame_close = flag && (state_q == CODE) && (data == 8'h00) && seen_code_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frames_q    <= 16'h0000;
            errors_q    <= 16'h0000;
            seen_code_q <= 1'b0;
        end else begin
            if (flag && data == 8'h00) seen_code_q <= 1'b0;
            else if (flag && state_q == CODE) seen_code_q <= 1'b1;
            if (frame_close) frames_q <= frames_q + 16'd1;
            if (err_d || drop) errors_q <= errors_q + 16'd1;
        end
    end

    assign o_frames = frames_q;
    assign o_errors = errors_q;
`endif

    assign o_flag     = o_flag_q;
    assign o_data     = o_data_q;
    assign o_sof      = sof_q;
    assign o_err      = err_q;
    assign o_ovf      = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_cobs_rx_decoder.sv
// tb/tb_cobs_rx_decoder.sv - self-checking bench for cobs_rx_decoder against a byte-level COBS model
module tb_cobs_rx_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flag = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy = 1'b0;
    logic       o_flag, o_sof, o_err, o_ovf;
    logic [7:0] o_data;
    logic [4:0] fifo_level;

    cobs_rx_decoder #(.FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .flag(flag), .data(data), .busy(busy),
        .o_flag(o_flag), .o_data(o_data), .o_sof(o_sof), .o_err(o_err),
        .o_ovf(o_ovf), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: COBS decoded at the byte level into a queue, drained by the spec's strobe rule
    int         mode = 0;          // 0 = hunting for delimiter, 1 = expect code, 2 = inside block
    int         remain = 0;
    bit         pend = 0;
    logic [7:0] mq[$];
    bit         m_flag = 0, m_sof = 0, m_err = 0, m_ovf = 0;
    logic [7:0] m_data = 0;
    bit         started = 0;

    always @(posedge clk) begin
        bit         n_sof, n_err, pushv, popv;
        logic [7:0] pv;
        cyc++;
        started = 1;
        if (!rst) begin
            mode = 0; remain = 0; pend = 0; mq.delete();
            m_flag = 0; m_sof = 0; m_err = 0; m_ovf = 0; m_data = 0;
        end else begin
            n_sof = 0; n_err = 0; pushv = 0; pv = 0;
            if (flag) begin
                if (mode == 0) begin
                    if (data == 0) begin n_sof = 1; mode = 1; end
                end else if (data == 0) begin
                    n_sof = 1;
                    if (mode == 2) n_err = 1;
                    mode = 1;
                    pend = 0;
                end else if (mode == 1) begin
                    if (pend) begin pushv = 1; pv = 8'h00; end
                    remain = int'(data) - 1;
                    pend = (data != 8'hFF);
                    mode = (remain > 0) ? 2 : 1;
                end else begin
                    pushv = 1; pv = data;
                    remain--;
                    if (remain == 0) mode = 1;
                end
            end
            popv = (mq.size() > 0) && !busy && !m_flag;
            if (popv) m_data = mq.pop_front();
            if (pushv) begin
                if (mq.size() < 16) mq.push_back(pv);
                else m_ovf = 1;
            end
            m_flag = popv; m_sof = n_sof; m_err = n_err;
        end
    end

    logic [7:0] got[$];
    int         tstamp[$];
    int         sof_cnt = 0, err_cnt = 0, flag_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("o_flag", o_flag, m_flag);
            chk("o_data", o_data, m_data);
            chk("o_sof", o_sof, m_sof);
            chk("o_err", o_err, m_err);
            chk("o_ovf", o_ovf, m_ovf);
            chk("fifo_level", fifo_level, mq.size());
            if (o_flag) begin got.push_back(o_data); tstamp.push_back(cyc); flag_cnt++; end
            if (o_sof) sof_cnt++;
            if (o_err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        flag = 1'b1; data = b;
        tick();
        flag = 1'b0;
        tick();
    endtask

    task automatic clear_log();
        got.delete(); tstamp.delete();
        sof_cnt = 0; err_cnt = 0; flag_cnt = 0;
    endtask

    task automatic chk_got(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, exp[i]);
    endtask

    initial begin
        logic [7:0] e[$];
        repeat (3) tick();
        chk("reset_level", fifo_level, 0);
        chk("reset_flag", o_flag, 0);
        chk("reset_data", o_data, 0);
        rst = 1'b1;
        tick();

        // 1: basic frame with implicit zero, none trailing
        clear_log();
        foreach (e[i]) e.delete();
        e = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        foreach (e[i]) send(e[i]);
        repeat (12) tick();
        chk_got("t1_byte", '{8'h11, 8'h22, 8'h00, 8'h33});
        chk("t1_sof", sof_cnt, 2);
        chk("t1_err", err_cnt, 0);

        // 2: 0xFF block does not add an implicit zero
        clear_log();
        send(8'h00); send(8'hFF);
        for (int i = 1; i <= 254; i++) send(8'(i));
        send(8'h01); send(8'h00);
        repeat (12) tick();
        e.delete();
        for (int i = 1; i <= 254; i++) e.push_back(8'(i));
        chk_got("t2_byte", e);

        // 3: busy throttling and strobe spacing
        clear_log();
        busy = 1'b1;
        send(8'h00); send(8'h04); send(8'hA1); send(8'hA2); send(8'hA3); send(8'h00);
        repeat (50) tick();
        chk("t3_noflag", flag_cnt, 0);
        chk("t3_level", fifo_level, 3);
        busy = 1'b0;
        repeat (12) tick();
        chk_got("t3_byte", '{8'hA1, 8'hA2, 8'hA3});
        for (int i = 1; i < tstamp.size(); i++)
            chk("t3_spacing_ge2", (tstamp[i] - tstamp[i-1]) >= 2, 1);

        // 4: delimiter inside a block is a framing error, decoding resumes cleanly
        clear_log();
        send(8'h00); send(8'h05); send(8'hAA); send(8'h00);
        send(8'h02); send(8'hBB); send(8'h00);
        repeat (12) tick();
        chk_got("t4_byte", '{8'hAA, 8'hBB});
        chk("t4_err", err_cnt, 1);
        chk("t4_sof", sof_cnt, 3);

        // 5: overflow drops bytes beyond 16, keeps order of the rest
        clear_log();
        busy = 1'b1;
        send(8'h00); send(8'h15);
        for (int i = 0; i < 20; i++) send(8'(8'h31 + i));
        tick();
        chk("t5_level", fifo_level, 16);
        chk("t5_ovf", o_ovf, 1);
        busy = 1'b0;
        repeat (40) tick();
        e.delete();
        for (int i = 0; i < 16; i++) e.push_back(8'(8'h31 + i));
        chk_got("t5_byte", e);
        chk("t5_ovf_sticky", o_ovf, 1);
        chk("t5_level_empty", fifo_level, 0);

        // 6: reset mid-block, then IDLE ignores bytes until a delimiter
        send(8'h00); send(8'h04); send(8'h55);
        rst = 1'b0;
        tick();
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_ovf", o_ovf, 0);
        chk("t6_rst_flag", o_flag, 0);
        chk("t6_rst_data", o_data, 0);
        rst = 1'b1;
        clear_log();
        send(8'h03); send(8'h44);
        send(8'h00); send(8'h02); send(8'h66); send(8'h00);
        repeat (12) tick();
        chk_got("t6_byte", '{8'h66});
        chk("t6_sof", sof_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
